// File: rtl/pio_edge_irq_multi_pkg.sv
// Shared definitions for the multi-channel edge-capture PIO: register
// offsets of the Avalon-MM register map and the channel-count ceiling.
package pio_edge_irq_multi_pkg;

    localparam int MAX_WIDTH = 32;

    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_RISE_EN      = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK     = 3'd2;
    localparam logic [2:0] ADDR_EDGE_CAPTURE = 3'd3;
    localparam logic [2:0] ADDR_FALL_EN      = 3'd4;
    localparam logic [2:0] ADDR_FILTER_CFG   = 3'd5;
    localparam logic [2:0] ADDR_PENDING      = 3'd6;
    localparam logic [2:0] ADDR_RESERVED     = 3'd7;

endpackage

// File: rtl/pio_input_filter.sv
// One input channel: multi-flop synchroniser followed by a glitch filter.
// The filtered output only follows the synchronised input after the two
// have disagreed on threshold+1 consecutive clocks.
module pio_input_filter
    import pio_edge_irq_multi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   din,
    input  logic [FILTER_BITS-1:0] threshold,
    input  logic                   clr_cnt,
    output logic                   filt
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FILTER_BITS-1:0] cnt_q, cnt_d;
    logic                   filt_q, filt_d;
    logic                   sync_s;

    assign sync_s = sync_q[SYNC_STAGES-1];
    assign filt   = filt_q;

    // Shift the raw input through the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
    end

    // Count consecutive disagreement cycles; accept the new level at threshold.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync_s == filt_q) begin
            cnt_d = {FILTER_BITS{1'b0}};
        end else if (cnt_q == threshold) begin
            filt_d = sync_s;
            cnt_d  = {FILTER_BITS{1'b0}};
        end else begin
            cnt_d = cnt_q + FILTER_BITS'(1'b1);
        end
        // A new threshold restarts every qualification window.
        if (clr_cnt) begin
            cnt_d = {FILTER_BITS{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            cnt_q  <= {FILTER_BITS{1'b0}};
            filt_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

endmodule

// File: rtl/pio_edge_irq_multi.sv
// Multi-channel PIO input port with per-bit glitch filter, programmable
// rising/falling edge detection, sticky edge capture and a masked level IRQ.
module pio_edge_irq_multi
    import pio_edge_irq_multi_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_BITS = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0]       filt_s, ev_s, w1c_s;
    logic [WIDTH-1:0]       rise_en_q, rise_en_d;
    logic [WIDTH-1:0]       fall_en_q, fall_en_d;
    logic [WIDTH-1:0]       irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0]       edge_cap_q, edge_cap_d;
    logic [WIDTH-1:0]       filt_prev_q, filt_prev_d;
    logic [FILTER_BITS-1:0] filter_cfg_q, filter_cfg_d;
    logic [31:0]            readdata_q, readdata_d;
    logic                   wr_s, cfg_wr_s;
    logic                   unused_s;

    assign wr_s     = chipselect && !write_n;
    assign cfg_wr_s = wr_s && (address == ADDR_FILTER_CFG);
    assign readdata = readdata_q;
    assign irq      = |(edge_cap_q & irq_mask_q);
    // Upper write-data bits beyond the channel/threshold widths carry no state.
    assign unused_s = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        pio_input_filter #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_BITS (FILTER_BITS)
        ) u_filt (
            .clk       (clk),
            .reset_n   (reset_n),
            .din       (in_port[i]),
            .threshold (filter_cfg_q),
            .clr_cnt   (cfg_wr_s),
            .filt      (filt_s[i])
        );
    end

    // Register writes, edge detection and sticky capture with set-over-clear.
    always_comb begin
        rise_en_d    = rise_en_q;
        fall_en_d    = fall_en_q;
        irq_mask_d   = irq_mask_q;
        filter_cfg_d = filter_cfg_q;
        w1c_s        = {WIDTH{1'b0}};
        if (wr_s) begin
            case (address)
                ADDR_RISE_EN:      rise_en_d    = writedata[WIDTH-1:0];
                ADDR_IRQ_MASK:     irq_mask_d   = writedata[WIDTH-1:0];
                ADDR_EDGE_CAPTURE: w1c_s        = writedata[WIDTH-1:0];
                ADDR_FALL_EN:      fall_en_d    = writedata[WIDTH-1:0];
                ADDR_FILTER_CFG:   filter_cfg_d = writedata[FILTER_BITS-1:0];
                default:           w1c_s        = {WIDTH{1'b0}};
            endcase
        end else begin
            w1c_s = {WIDTH{1'b0}};
        end
        ev_s        = (filt_s & ~filt_prev_q & rise_en_q) |
                      (~filt_s & filt_prev_q & fall_en_q);
        edge_cap_d  = ev_s | (edge_cap_q & ~w1c_s);
        filt_prev_d = filt_s;
    end

    // Read mux; unused upper bits and reserved addresses return zero.
    always_comb begin
        readdata_d = 32'd0;
        case (address)
            ADDR_DATA:         readdata_d[WIDTH-1:0]       = filt_s;
            ADDR_RISE_EN:      readdata_d[WIDTH-1:0]       = rise_en_q;
            ADDR_IRQ_MASK:     readdata_d[WIDTH-1:0]       = irq_mask_q;
            ADDR_EDGE_CAPTURE: readdata_d[WIDTH-1:0]       = edge_cap_q;
            ADDR_FALL_EN:      readdata_d[WIDTH-1:0]       = fall_en_q;
            ADDR_FILTER_CFG:   readdata_d[FILTER_BITS-1:0] = filter_cfg_q;
            ADDR_PENDING:      readdata_d[WIDTH-1:0]       = edge_cap_q & irq_mask_q;
            default:           readdata_d                  = 32'd0;
        endcase
    end

    // Register file, edge history and read-data registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rise_en_q    <= {WIDTH{1'b0}};
            fall_en_q    <= {WIDTH{1'b0}};
            irq_mask_q   <= {WIDTH{1'b0}};
            edge_cap_q   <= {WIDTH{1'b0}};
            filt_prev_q  <= {WIDTH{1'b0}};
            filter_cfg_q <= {FILTER_BITS{1'b0}};
            readdata_q   <= 32'd0;
        end else begin
            rise_en_q    <= rise_en_d;
            fall_en_q    <= fall_en_d;
            irq_mask_q   <= irq_mask_d;
            edge_cap_q   <= edge_cap_d;
            filt_prev_q  <= filt_prev_d;
            filter_cfg_q <= filter_cfg_d;
            readdata_q   <= readdata_d;
        end
    end

endmodule

// File: tb/tb_pio_edge_irq_multi.sv
// Scoreboard bench for pio_edge_irq_multi: a behavioural model predicts
// readdata and irq for every clock; a monitor compares them a half cycle later.
module tb_pio_edge_irq_multi;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FILTER_BITS = 8;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [2:0]       address = 3'd0;
    logic             chipselect = 1'b0;
    logic             write_n = 1'b1;
    logic [31:0]      writedata = 32'd0;
    logic [WIDTH-1:0] in_port = 8'd0;
    logic [31:0]      readdata;
    logic             irq;

    int checks = 0;
    int errors = 0;

    pio_edge_irq_multi #(
        .WIDTH (WIDTH), .SYNC_STAGES (SYNC_STAGES), .FILTER_BITS (FILTER_BITS)
    ) dut (
        .clk (clk), .reset_n (reset_n), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .in_port (in_port),
        .readdata (readdata), .irq (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit [31:0] rd;
        bit        irq;
        bit [2:0]  addr;
    } exp_t;

    exp_t     sbq[$];
    bit [7:0] hist[$];
    bit [7:0] m_filt, m_prev, m_rise, m_fall, m_mask, m_cap;
    int       m_thr;
    int       m_run[WIDTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: sticky flags, enables and a "level must persist
    // threshold+1 clocks" filter behind a fixed-length input delay.
    bit [31:0] mr_rd;
    bit [7:0]  mr_sync, mr_ev, mr_clr;
    bit        mr_wr;
    exp_t      mr_e;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_filt = 8'h00; m_prev = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
            m_mask = 8'h00; m_cap = 8'h00; m_thr = 0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
            hist.delete();
            sbq.delete();
        end else begin
            case (address)
                3'd0: mr_rd = {24'd0, m_filt};
                3'd1: mr_rd = {24'd0, m_rise};
                3'd2: mr_rd = {24'd0, m_mask};
                3'd3: mr_rd = {24'd0, m_cap};
                3'd4: mr_rd = {24'd0, m_fall};
                3'd5: mr_rd = 32'(m_thr);
                3'd6: mr_rd = {24'd0, m_cap & m_mask};
                default: mr_rd = 32'd0;
            endcase
            mr_wr  = chipselect && !write_n;
            mr_ev  = (m_filt & ~m_prev & m_rise) | (~m_filt & m_prev & m_fall);
            mr_clr = (mr_wr && address == 3'd3) ? writedata[7:0] : 8'h00;
            m_cap  = mr_ev | (m_cap & ~mr_clr);
            m_prev = m_filt;
            // Synchronised view is the input as sampled SYNC_STAGES clocks ago.
            mr_sync = (hist.size() >= SYNC_STAGES) ? hist[hist.size() - SYNC_STAGES] : 8'h00;
            for (int i = 0; i < WIDTH; i++) begin
                if (mr_sync[i] != m_filt[i]) begin
                    m_run[i]++;
                    if (m_run[i] == m_thr + 1) begin
                        m_filt[i] = mr_sync[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            if (mr_wr) begin
                case (address)
                    3'd1: m_rise = writedata[7:0];
                    3'd2: m_mask = writedata[7:0];
                    3'd4: m_fall = writedata[7:0];
                    3'd5: begin
                        m_thr = int'(writedata[7:0]);
                        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
                    end
                    default: ;
                endcase
            end
            hist.push_back(in_port);
            if (hist.size() > SYNC_STAGES) void'(hist.pop_front());
            mr_e.rd   = mr_rd;
            mr_e.irq  = |(m_cap & m_mask);
            mr_e.addr = address;
            sbq.push_back(mr_e);
        end
    end

    // Monitor: compare the registered outputs against the predicted values.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset_n) begin
            check("reset_readdata", readdata, 32'd0);
            check("reset_irq", 32'(irq), 32'd0);
        end else if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            check($sformatf("readdata_addr%0d", mon_e.addr), readdata, mon_e.rd);
            check("irq", 32'(irq), 32'(mon_e.irq));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        @(negedge clk);
    endtask

    task automatic mid_reset();
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_readdata", readdata, 32'd0);
        check("async_reset_irq", 32'(irq), 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int r;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // 1: rising edge latency and W1C drop of irq
        wr(3'd5, 32'd0); wr(3'd1, 32'h01); wr(3'd2, 32'h01); wr(3'd3, 32'hFF);
        in_port[0] = 1'b1;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (irq && lat < 0) begin
                lat = k;
                break;
            end
        end
        check("irq_latency", 32'(lat), 32'(SYNC_STAGES + 2));
        wr(3'd3, 32'h01);
        check("irq_after_w1c", 32'(irq), 32'd0);

        // 2: glitch filter with T=4
        wr(3'd5, 32'd4); wr(3'd1, 32'h02); wr(3'd2, 32'h00); wr(3'd3, 32'hFF);
        address = 3'd0;
        in_port[1] = 1'b1; step(3); in_port[1] = 1'b0; step(12);
        rd(3'd3);
        check("short_pulse_capture", readdata, 32'h00);
        address = 3'd0;
        in_port[1] = 1'b1; step(6); in_port[1] = 1'b0; step(14);
        rd(3'd3);
        check("long_pulse_capture", readdata, 32'h02);

        // 3: falling-edge only
        wr(3'd1, 32'h00); wr(3'd4, 32'h04); wr(3'd5, 32'd0); wr(3'd3, 32'hFF);
        in_port[2] = 1'b1; step(6);
        rd(3'd3);
        check("fall_only_no_rise", readdata, 32'h00);
        in_port[2] = 1'b0; step(6);
        rd(3'd3);
        check("fall_capture", readdata, 32'h04);

        // 4: set wins over simultaneous W1C; W1C of other bits leaves flags
        wr(3'd3, 32'hFF); wr(3'd4, 32'h00); wr(3'd1, 32'h08);
        in_port[3] = 1'b1; step(SYNC_STAGES + 1);
        wr(3'd3, 32'h08);
        rd(3'd3);
        check("set_beats_w1c", readdata, 32'h08);
        wr(3'd1, 32'h0F);
        in_port[0] = 1'b0; step(6);
        in_port[2:0] = 3'b111; step(6);
        wr(3'd3, 32'hF0);
        rd(3'd3);
        check("w1c_other_bits", readdata, 32'h0F);

        // 5: mask and pending
        wr(3'd2, 32'h00);
        rd(3'd6);
        check("pending_masked", readdata, 32'h00);
        check("irq_masked", 32'(irq), 32'd0);
        wr(3'd2, 32'h08);
        rd(3'd6);
        check("pending_bit3", readdata, 32'h08);
        check("irq_unmasked", 32'(irq), 32'd1);
        rd(3'd7);
        check("reserved_reads_zero", readdata, 32'h00);

        // 6: reset mid-count with flags set, then DATA tracks inputs
        wr(3'd5, 32'd4); wr(3'd1, 32'hFF);
        in_port[4] = 1'b1; step(4);
        mid_reset();
        step(6);
        rd(3'd0);
        check("data_after_reset", readdata, {24'd0, in_port});

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
            r = $urandom_range(0, 9);
            address = 3'($urandom_range(0, 7));
            if (r < 2) begin
                writedata  = (address == 3'd5) ? 32'($urandom_range(0, 3)) : $urandom;
                chipselect = 1'b1; write_n = 1'b0;
            end else begin
                writedata  = $urandom;
                chipselect = r[0]; write_n = 1'b1;
            end
            @(negedge clk);
            chipselect = 1'b0; write_n = 1'b1;
            if (n == 700) mid_reset();
        end

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
